// File: rtl/align_buffer_seq.sv
// align_buffer_seq: per-row clear/fill/drain sequencer for the disparity align buffer.
// Optional stall statistic is built when ALIGN_SEQ_STATS_EN is defined.
module align_buffer_seq #(
  parameter int WIDTH      = 80,
  parameter int CWIDTH     = 11,
  parameter int CLR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        cfg_range,
  input  logic [CWIDTH-1:0] cfg_width,
  input  logic              row_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              buf_rst,
  output logic              buf_clken,
  output logic [8:0]        buf_range,
  output logic [WIDTH-1:0]  buf_din,
  input  logic              buf_rd_en_n,
  input  logic [WIDTH-1:0]  buf_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              row_done,
  output logic              err_overrun,
  output logic [15:0]       stat_stall_cnt
);

  localparam int CLRW = (CLR_CYCLES > 2) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLRW-1:0] CLR_LAST = CLRW'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [8:0]        range_q, range_d;
  logic [CWIDTH-1:0] width_q, width_d;
  logic [CWIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [CWIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [9:0]        drain_cnt_q, drain_cnt_d;
  logic [CLRW-1:0]   clr_cnt_q, clr_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              cap_pend_q, cap_pend_d;
  logic              err_q, err_d;

  logic              step;
  logic              pend_live;
  logic              capture;
  logic              need_step;
  logic              row_go;
  logic [CWIDTH:0]   words_seen;

  always_comb begin
    step       = !out_valid_q | out_ready;
    pend_live  = cap_pend_q & !buf_rd_en_n;
    capture    = pend_live & step & (out_cnt_q < width_q);
    words_seen = {1'b0, out_cnt_q} + {{CWIDTH{1'b0}}, pend_live};
    need_step  = words_seen < {1'b0, width_q};
    row_go     = (state_q == S_IDLE) & row_start;
  end

  always_comb begin
    state_d     = state_q;
    range_d     = range_q;
    width_d     = width_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    drain_cnt_d = drain_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    cap_pend_d  = cap_pend_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    buf_rst     = 1'b1;
    buf_clken   = 1'b0;
    buf_din     = '0;
    row_done    = 1'b0;

    // A buffer step leaves a pending capture that waits for a free slot.
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = buf_dout;
      out_last_d  = (out_cnt_q == width_q - CWIDTH'(1));
      out_cnt_d   = out_cnt_q + CWIDTH'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (row_start) begin
          range_d     = (cfg_range == 9'd0) ? 9'd1 : cfg_range;
          width_d     = cfg_width;
          err_d       = 1'b0;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          drain_cnt_d = '0;
          clr_cnt_d   = '0;
          state_d     = (cfg_width == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        buf_rst   = 1'b0;
        clr_cnt_d = clr_cnt_q + CLRW'(1);
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        in_ready = step;
        if (in_valid && step) begin
          buf_clken = 1'b1;
          buf_din   = in_data;
          in_cnt_d  = in_cnt_q + CWIDTH'(1);
          if (in_cnt_q + CWIDTH'(1) == width_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_cnt_q == width_q) begin
          if (step) begin
            state_d = S_DONE;
          end
        end else if (step && need_step) begin
          buf_clken   = 1'b1;
          drain_cnt_d = drain_cnt_q + 10'd1;
          if (drain_cnt_d > ({1'b0, range_q} + 10'd4)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        row_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (buf_clken) begin
      cap_pend_d = 1'b1;
    end else if (step) begin
      cap_pend_d = 1'b0;
    end
    if (row_go) begin
      cap_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      range_q     <= '0;
      width_q     <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      drain_cnt_q <= '0;
      clr_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cap_pend_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      range_q     <= range_d;
      width_q     <= width_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      cap_pend_q  <= cap_pend_d;
      err_q       <= err_d;
    end
  end

`ifdef ALIGN_SEQ_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (row_go) begin
      stall_d = '0;
    end else if (state_q == S_FILL && !(in_valid && step)
                 && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stat_stall_cnt = stall_q;
`else
  assign stat_stall_cnt = 16'd0;
`endif

  assign buf_range   = range_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign err_overrun = err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_align_buffer_seq.sv
// tb_align_buffer_seq: randomized rows against a queue-based delay-line buffer
// model and an in-order scoreboard of accepted input words.
module tb_align_buffer_seq;

  localparam int W  = 80;
  localparam int CW = 11;
  localparam logic [192:0] RST_VEC =
    {1'b0, 1'b1, 1'b0, 9'd0, 80'd0, 1'b0, 80'd0,
     1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [8:0]    cfg_range = '0;
  logic [CW-1:0] cfg_width = '0;
  logic          row_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          buf_rst;
  logic          buf_clken;
  logic [8:0]    buf_range;
  logic [W-1:0]  buf_din;
  logic          buf_rd_en_n = 1'b1;
  logic [W-1:0]  buf_dout = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          row_done;
  logic          err_overrun;
  logic [15:0]   stat_stall_cnt;

  int vecs = 0;
  int errs = 0;
  bit never_valid = 1'b0;

  always #5 clk = ~clk;

  align_buffer_seq dut (
    .clk(clk), .rst(rst),
    .cfg_range(cfg_range), .cfg_width(cfg_width),
    .row_start(row_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .buf_rst(buf_rst), .buf_clken(buf_clken),
    .buf_range(buf_range), .buf_din(buf_din),
    .buf_rd_en_n(buf_rd_en_n), .buf_dout(buf_dout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .row_done(row_done),
    .err_overrun(err_overrun), .stat_stall_cnt(stat_stall_cnt)
  );

  // Delay line: a word written at step k is presented after step k+range.
  logic [W-1:0] bq[$];
  always @(posedge clk) begin
    if (!buf_rst) begin
      bq.delete();
      buf_rd_en_n <= 1'b1;
      buf_dout    <= '0;
    end else if (buf_clken) begin
      bq.push_back(buf_din);
      if (bq.size() > int'(buf_range)) begin
        buf_dout    <= bq.pop_front();
        buf_rd_en_n <= never_valid;
      end else begin
        buf_rd_en_n <= 1'b1;
      end
    end
  end

  function automatic logic [192:0] outs_vec();
    return {in_ready, buf_rst, buf_clken, buf_range, buf_din,
            out_valid, out_data, out_last, busy, row_done,
            err_overrun, stat_stall_cnt};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic pulse_row(input int rng, input int wid);
    cfg_range = 9'(rng);
    cfg_width = CW'(wid);
    row_start = 1'b1;
    @(posedge clk); #1;
    row_start = 1'b0;
  endtask

  // rmode: 0 ready high, 1 toggle, 2 random. vmode: 0 valid high,
  // 1 random, 2 three-cycle gap after two accepted words.
  task automatic run_row(input int rng, input int wid,
                         input int rmode, input int vmode);
    logic [W-1:0] exq[$];
    logic [W-1:0] expw;
    int acc = 0, outs = 0, drn = 0, clr = 0, stall = 0;
    int viol = 0, trk = 0, cyc = 0, gap = 3;
    int first_acc = -1, first_out = -1, last_cons = -1, done_cyc = -1;
    int reff = (rng == 0) ? 1 : rng;
    int exp_stat;
    bit fill;
    bit done = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    pulse_row(rng, wid);
    vecs++;
    if (err_overrun !== 1'b0) begin
      errs++;
      $display("FAIL err_clear got=%b want=0", err_overrun);
    end
    while (!done && cyc < 600) begin
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      case (vmode)
        0: in_valid = 1'b1;
        1: in_valid = ($urandom_range(0, 3) != 0);
        default: begin
          if (acc == 2 && gap > 0) begin
            in_valid = 1'b0;
            gap--;
          end else begin
            in_valid = 1'b1;
          end
        end
      endcase
      in_data = rnd_word();
      #1;
      if (!buf_rst) clr++;
      fill = (clr > 0) && buf_rst && (acc < wid);
      if (fill && !(in_valid && in_ready)) stall++;
      if (fill && in_ready !== (!out_valid || out_ready)) trk++;
      if (out_valid && !out_ready && buf_clken) viol++;
      if (in_valid && in_ready) begin
        if (!fill || buf_clken !== 1'b1 || buf_din !== in_data) viol++;
        exq.push_back(in_data);
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end else if (buf_clken) begin
        drn++;
        if (buf_din !== '0 || acc < wid) viol++;
      end
      if (out_valid && first_out < 0) first_out = cyc;
      if (out_valid && out_ready) begin
        expw = (exq.size() > 0) ? exq.pop_front() : 'x;
        vecs++;
        if (out_data !== expw || out_last !== (outs == wid - 1)) begin
          errs++;
          $display("FAIL word[%0d] got=%h last=%b want=%h last=%b",
                   outs, out_data, out_last, expw, (outs == wid - 1));
        end
        outs++;
        last_cons = cyc;
      end
      if (row_done) begin
        done = 1'b1;
        done_cyc = cyc;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    vecs++;
    if (!done) begin
      errs++;
      $display("FAIL row_timeout got=%0d cycles want=row_done", cyc);
    end
    vecs++;
    if (outs != wid) begin
      errs++;
      $display("FAIL out_count got=%0d want=%0d", outs, wid);
    end
    vecs++;
    if (wid > 0 && drn != reff) begin
      errs++;
      $display("FAIL drain_steps got=%0d want=%0d", drn, reff);
    end
    vecs++;
    if (clr != ((wid > 0) ? 2 : 0)) begin
      errs++;
      $display("FAIL clear_cycles got=%0d want=%0d", clr, (wid > 0) ? 2 : 0);
    end
    vecs++;
    if (wid > 0 && done_cyc != last_cons + 1) begin
      errs++;
      $display("FAIL done_timing got=%0d want=%0d", done_cyc, last_cons + 1);
    end
    vecs++;
    if (err_overrun !== 1'b0 || buf_range !== 9'(reff)) begin
      errs++;
      $display("FAIL row_status got err=%b range=%0d want err=0 range=%0d",
               err_overrun, buf_range, reff);
    end
    vecs++;
    if (viol != 0 || trk != 0) begin
      errs++;
      $display("FAIL handshake got viol=%0d trk=%0d want 0 0", viol, trk);
    end
`ifdef ALIGN_SEQ_STATS_EN
    exp_stat = stall;
`else
    exp_stat = 0;
`endif
    vecs++;
    if (stat_stall_cnt !== 16'(exp_stat)) begin
      errs++;
      $display("FAIL stall_stat got=%0d want=%0d", stat_stall_cnt, exp_stat);
    end
    if (rmode == 0 && vmode == 0) begin
      vecs++;
      if (first_out - first_acc != reff + 2) begin
        errs++;
        $display("FAIL latency got=%0d want=%0d", first_out - first_acc, reff + 2);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (busy !== 1'b0 || row_done !== 1'b0) begin
      errs++;
      $display("FAIL idle_return got busy=%b done=%b want 0 0", busy, row_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (outs_vec() !== RST_VEC) begin
      errs++;
      $display("FAIL reset_values got=%h want=%h", outs_vec(), RST_VEC);
    end
    #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_row(4, 8, 0, 0);
  endtask

  task automatic test_backpressure();
    run_row(4, 8, 1, 0);
  endtask

  task automatic test_range_zero();
    run_row(0, 3, 0, 0);
  endtask

  task automatic test_zero_width();
    int seen = 0;
    pulse_row(3, 0);
    vecs++;
    if (busy !== 1'b1 || row_done !== 1'b1 || buf_rst !== 1'b1) begin
      errs++;
      $display("FAIL zero_width got busy=%b done=%b rst=%b want 1 1 1",
               busy, row_done, buf_rst);
    end
    for (int i = 0; i < 4; i++) begin
      if (out_valid || busy) seen++;
      @(posedge clk); #1;
    end
    vecs++;
    if (seen != 1) begin
      errs++;
      $display("FAIL zero_width_tail got=%0d busy/valid cycles want=1", seen);
    end
  endtask

  task automatic test_overrun();
    int acc = 0, drn = 0, outs = 0, cyc = 0;
    bit done = 1'b0;
    logic errv = 1'b0;
    never_valid = 1'b1;
    out_ready = 1'b1;
    pulse_row(4, 4);
    while (!done && cyc < 200) begin
      in_valid = 1'b1;
      in_data = rnd_word();
      #1;
      if (in_valid && in_ready) acc++;
      else if (buf_clken) drn++;
      if (out_valid) outs++;
      if (row_done) begin
        done = 1'b1;
        errv = err_overrun;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    vecs++;
    if (!done || drn != 9 || errv !== 1'b1 || outs != 0) begin
      errs++;
      $display("FAIL overrun got done=%b drain=%0d err=%b outs=%0d want 1 9 1 0",
               done, drn, errv, outs);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (err_overrun !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL overrun_sticky got err=%b busy=%b want 1 0", err_overrun, busy);
    end
    never_valid = 1'b0;
    run_row(4, 4, 0, 0);
  endtask

  task automatic test_mid_reset();
    int acc = 0, n = 0;
    out_ready = 1'b1;
    pulse_row(4, 8);
    while (acc < 5 && n < 100) begin
      in_valid = 1'b1;
      in_data = rnd_word();
      #1;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      n++;
    end
    vecs++;
    if (acc != 5 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_fill got acc=%0d busy=%b want 5 1", acc, busy);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (outs_vec() !== RST_VEC) begin
      errs++;
      $display("FAIL mid_reset got=%h want=%h", outs_vec(), RST_VEC);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    run_row(4, 8, 0, 0);
  endtask

  task automatic test_stats();
    int want;
`ifdef ALIGN_SEQ_STATS_EN
    want = 3;
`else
    want = 0;
`endif
    run_row(2, 4, 0, 2);
    vecs++;
    if (stat_stall_cnt !== 16'(want)) begin
      errs++;
      $display("FAIL stats_gap got=%0d want=%0d", stat_stall_cnt, want);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 6; r++) begin
      run_row($urandom_range(0, 8), $urandom_range(1, 12), 2, 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_range_zero();
    test_zero_width();
    test_overrun();
    test_mid_reset();
    test_stats();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1, "timeout");
  end

endmodule
